// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    // Transaction phases: waiting for a request, burning wait states, responding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    // Width of the wait-state down-counter (covers 0..15 wait states).
    localparam int WAIT_W = 4;

    // Data returned for error loads and for every store response.
    localparam logic [31:0] DMEM_ERR_DATA = 32'h0;

    // True when the word index of a byte address falls outside the array.
    function automatic logic out_of_range(input logic [31:0] byte_addr,
                                          input int unsigned depth_words);
        return (byte_addr >> 2) >= depth_words;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-wide storage with byte-enable synchronous write and synchronous read.
module dmem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [3:0]       wr_be,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wr_data,
    output logic [31:0]      rd_data
);

    logic [31:0] mem [DEPTH_WORDS];

    // Byte-lane writes and registered read; the read register holds between reads.
    // NOTE: no reset here -- resetting a RAM array prevents block-RAM inference and
    // its contents are architecturally undefined after reset anyway.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
        if (rd_en) begin
            rd_data <= mem[idx];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the load/store port: one request at a time,
// fixed wait-state latency, registered full-word response.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_req,
    input  logic        we_re,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  mask,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [WAIT_W-1:0] CNT_LOAD =
        (WAIT_CYCLES > 0) ? WAIT_W'(WAIT_CYCLES - 1) : '0;

    dmem_state_t       state, state_nxt;
    logic              accept;
    logic              enter_resp;
    logic [WAIT_W-1:0] cnt;

    logic              lat_we;
    logic [31:0]       lat_addr;
    logic [31:0]       lat_wdata;
    logic [3:0]        lat_mask;

    logic              cur_we;
    logic [31:0]       cur_addr;
    logic [31:0]       cur_wdata;
    logic [3:0]        cur_mask;
    logic              cur_err;

    logic              arr_wr_en;
    logic              arr_rd_en;
    logic [31:0]       arr_rdata;
    logic              rsp_is_load;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and state-decoded outputs; req_ready depends on state only.
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (mem_req) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_nxt  = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt  = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Wait-state down-counter: loaded at accept, counts to zero in WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= CNT_LOAD;
        end else if (state == WAIT && cnt != '0) begin
            cnt <= cnt - WAIT_W'(1);
        end
    end

    // Request latch: captures the command at accept, ignores inputs afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_mask  <= '0;
        end else if (accept) begin
            lat_we    <= we_re;
            lat_addr  <= addr;
            lat_wdata <= wdata;
            lat_mask  <= mask;
        end
    end

    // With zero wait states the commit edge is the accept edge, so the live
    // inputs stand in for the latch on that edge.
    assign cur_we    = accept ? we_re : lat_we;
    assign cur_addr  = accept ? addr  : lat_addr;
    assign cur_wdata = accept ? wdata : lat_wdata;
    assign cur_mask  = accept ? mask  : lat_mask;
    assign cur_err   = out_of_range(cur_addr, DEPTH_WORDS);

    // Array access only happens on the edge entering RESP, and never for errors.
    assign arr_wr_en = enter_resp &&  cur_we && !cur_err;
    assign arr_rd_en = enter_resp && !cur_we && !cur_err;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk     (clk),
        .wr_en   (arr_wr_en),
        .wr_be   (cur_mask),
        .rd_en   (arr_rd_en),
        .idx     (cur_addr[IDX_W+1:2]),
        .wr_data (cur_wdata),
        .rd_data (arr_rdata)
    );

    // Response flags: updated at each response, held until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err     <= 1'b0;
            rsp_is_load <= 1'b0;
        end else if (enter_resp) begin
            rsp_err     <= cur_err;
            rsp_is_load <= !cur_we && !cur_err;
        end
    end

    // Stores and error accesses return the constant; loads return the read register.
    assign rsp_rdata = rsp_is_load ? arr_rdata : DMEM_ERR_DATA;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the RV32I core: the memory-side end of the load/store interface driven by the memory stage. Accepts one request at a time (`mem_req`, `we_re`, byte `mask`, pre-aligned write data), applies a fixed configurable wait-state latency, and returns a registered 32-bit read word or write acknowledge. Byte/halfword extraction and sign extension of load data stay in the memory stage; this block always returns the full addressed word.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words in the array; power of two.
- `WAIT_CYCLES`, 2: wait states between accept and response; legal range 0..15.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `mem_req`  in  1  request strobe from the memory stage.
- `we_re`  in  1  1 = store, 0 = load; sampled with `mem_req`.
- `addr`  in  32  byte address; `addr[1:0]` is ignored, word index = `addr[31:2]`.
- `wdata`  in  32  store data, already lane-aligned by the memory stage.
- `mask`  in  4  byte enables for stores; ignored for loads.
- `req_ready`  out  1  block can accept a request this cycle.
- `rsp_valid`  out  1  one-cycle pulse: response complete.
- `rsp_rdata`  out  32  read word; held stable until the next response.
- `rsp_err`  out  1  out-of-range access; valid with `rsp_valid`, held with `rsp_rdata`.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: `req_ready` = 1. If `mem_req` = 1, the block latches `addr`, `we_re`, `wdata` and `mask`, then moves to WAIT, or straight to RESP when `WAIT_CYCLES` = 0.
- WAIT: a down-counter is loaded with `WAIT_CYCLES` − 1 at accept. When the counter reaches 0 the block moves to RESP.
- RESP: `rsp_valid` = 1 for exactly one cycle, then the block returns to IDLE.
- Inputs are ignored outside IDLE; requests are never queued.
- Range check: word index ≥ `DEPTH_WORDS` means an error access.
  - Error loads: `rsp_err` = 1, `rsp_rdata` = 0.
  - Error stores: `rsp_err` = 1, no write.
- Store commit: on the edge that enters RESP, each byte lane i with `mask[i]` = 1 is written. `mask` = 0000 writes nothing but still responds with `rsp_err` = 0.
- Load: `rsp_rdata` is registered from the array on the edge that enters RESP.
- Store response: `rsp_rdata` = 0 for every store response.
- There is no response backpressure; the memory stage must consume `rsp_valid` in its cycle.

## Timing
- Reset values (asynchronous assertion): state = IDLE, `req_ready` = 1, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0, counter = 0. Array contents are not reset.
- Latency: request accepted at edge k; `rsp_valid` is high during cycle k + 1 + `WAIT_CYCLES`.
- `req_ready` is low from the cycle after accept through the RESP cycle, and high again the cycle after RESP.
- Throughput: one transaction per `WAIT_CYCLES` + 2 cycles.
- `req_ready` is a function of state only; it has no combinational path from `mem_req`.
- Reset asserted mid-transaction: the transaction is dropped, no write occurs, and no response is issued.
- Back-to-back: `mem_req` held high continuously is accepted again in the first IDLE cycle after RESP.

## Structure
- Package `dmem_pkg`:
  - state enum (IDLE, WAIT, RESP);
  - `WAIT_W` = 4 (counter width);
  - error-data constant `DMEM_ERR_DATA` = 32'h0.
- Sub-module `dmem_array`:
  - `DEPTH_WORDS` × 32 storage with a 4-bit byte-enable synchronous write port;
  - synchronous read port;
  - no reset.
- Top level holds the FSM, request latch, wait counter, range check and response registers.

## Test plan
- Reset then idle: `rst_n` low → all outputs at reset values and `req_ready` = 1. Release `rst_n` with `mem_req` = 0 → no `rsp_valid` for 20 cycles.
- Full-word store then load, `WAIT_CYCLES` = 2:
  - store `addr` = 0x10, `wdata` = 0xDEADBEEF, `mask` = 1111 accepted at edge k → `rsp_valid` in cycle k+3;
  - load 0x10 → `rsp_rdata` = 0xDEADBEEF, `rsp_err` = 0.
- Byte-masked store: with word 0x10 = 0xDEADBEEF, store `wdata` = 0x00AA0000, `mask` = 0100 → a following load returns 0xDEAABEEF. A `mask` = 0000 store leaves the word unchanged.
- Out of range, `DEPTH_WORDS` = 1024:
  - load `addr` = 0x1000 → `rsp_err` = 1, `rsp_rdata` = 0;
  - store to 0x1000 with `mask` = 1111 → `rsp_err` = 1, and a load of 0x0 is unchanged (no aliasing).
- `WAIT_CYCLES` = 0 with `mem_req` held high for 6 cycles → exactly 3 responses, on cycles k+1, k+3, k+5; `req_ready` toggles 1,0,1,0…
- Reset mid-transaction: assert `rst_n` low during WAIT of a store → no `rsp_valid`, and the target word is unchanged after reset.
